frame_sequencer: RTL and testbench

Frame-level controller between the unpacker and the Gx/Gy Sobel pair. Passes pixels through while counting columns and rows of each frame. After the last input pixel it injects zero-valued flush pixels so the Sobel line buffers drain the final rows. It latches the output-mode selection only at frame start, so the packer never mixes modes within one frame.

---
 rtl/frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame-level pass/flush controller ahead of the Sobel pair
//
// Ports:
//   clk_i, reset_i          single clock, synchronous active-high reset
//   mode_req_i[2:0]         raw button levels, sampled only at frame start
//   valid_i/ready_o/data_i  upstream pixel stream from the unpacker
//   valid_o/ready_i/data_o  downstream pixel stream to the Gx/Gy filters
//   mode_o[1:0]             mode latched for the current frame
//   busy_o                  frame in progress (PASS or FLUSH)
//   frame_done_o            one-cycle pulse after the last beat of a frame
//   frame_cnt_o[7:0]        completed-frame counter, wraps at 256

module frame_sequencer #(
    parameter int width_p      = 320,
    parameter int height_p     = 240,
    parameter int data_width_p = 1,
    parameter int flush_rows_p = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [2:0]              mode_req_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [data_width_p-1:0] data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [data_width_p-1:0] data_o,
    output logic [1:0]              mode_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic [7:0]              frame_cnt_o
);

    localparam int rows_max_lp = (height_p > flush_rows_p) ? height_p : flush_rows_p;
    localparam int col_w_lp    = (width_p > 1) ? $clog2(width_p) : 1;
    localparam int row_w_lp    = (rows_max_lp > 1) ? $clog2(rows_max_lp) : 1;

    localparam logic [col_w_lp-1:0] col_last_lp        = col_w_lp'(width_p - 1);
    localparam logic [row_w_lp-1:0] row_last_pass_lp   = row_w_lp'(height_p - 1);
    // Unused when flush_rows_p is 0; the FLUSH state is then unreachable.
    localparam logic [row_w_lp-1:0] row_last_flush_lp  =
        (flush_rows_p > 0) ? row_w_lp'(flush_rows_p - 1) : '0;

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        PASS_S  = 2'd1,
        FLUSH_S = 2'd2
    } state_t;

    state_t              state;
    logic [col_w_lp-1:0] col;
    logic [row_w_lp-1:0] row;
    logic                handshake;
    logic                col_end;

    // One-hot button decode; anything ambiguous falls back to magnitude.
    function automatic logic [1:0] decode_mode(input logic [2:0] req);
        case (req)
            3'b001:  decode_mode = 2'd1;
            3'b010:  decode_mode = 2'd2;
            3'b100:  decode_mode = 2'd3;
            default: decode_mode = 2'd0;
        endcase
    endfunction

    // Stream muxing is combinational so PASS adds no latency and an
    // unaccepted pixel simply stays on data_i under upstream hold.
    always_comb begin
        valid_o = 1'b0;
        ready_o = 1'b0;
        data_o  = '0;
        case (state)
            PASS_S: begin
                valid_o = valid_i;
                ready_o = ready_i;
                data_o  = data_i;
            end
            FLUSH_S: begin
                valid_o = 1'b1;
                ready_o = 1'b0;
                data_o  = '0;
            end
            default: begin
                valid_o = 1'b0;
                ready_o = 1'b0;
                data_o  = '0;
            end
        endcase
    end

    assign handshake = valid_o & ready_i;
    assign col_end   = (col == col_last_lp);
    assign busy_o    = (state != IDLE_S);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE_S;
            col          <= '0;
            row          <= '0;
            mode_o       <= 2'd0;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= 8'd0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE_S: begin
                    col <= '0;
                    row <= '0;
                    if (valid_i) begin
                        state  <= PASS_S;
                        mode_o <= decode_mode(mode_req_i);
                    end
                end
                PASS_S: begin
                    if (handshake) begin
                        if (col_end) begin
                            col <= '0;
                            if (row == row_last_pass_lp) begin
                                row <= '0;
                                if (flush_rows_p > 0) begin
                                    state <= FLUSH_S;
                                end else begin
                                    state        <= IDLE_S;
                                    frame_done_o <= 1'b1;
                                    frame_cnt_o  <= frame_cnt_o + 8'd1;
                                end
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                FLUSH_S: begin
                    if (handshake) begin
                        if (col_end) begin
                            col <= '0;
                            if (row == row_last_flush_lp) begin
                                row          <= '0;
                                state        <= IDLE_S;
                                frame_done_o <= 1'b1;
                                frame_cnt_o  <= frame_cnt_o + 8'd1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE_S;
                    col   <= '0;
                    row   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer

module tb_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode_req;
    logic       valid_i;
    logic       data_i;
    logic       ready_i;

    logic       a_ready, a_valid, a_data, a_busy, a_done;
    logic [1:0] a_mode;
    logic [7:0] a_cnt;
    logic       b_ready, b_valid, b_data, b_busy, b_done;
    logic [1:0] b_mode;
    logic [7:0] b_cnt;

    int checks   = 0;
    int failures = 0;

    logic [11:0] pat = 12'b0110_0101_1101;

    always #5 clk = ~clk;

    frame_sequencer #(
        .width_p(4), .height_p(3), .data_width_p(1), .flush_rows_p(2)
    ) dut (
        .clk_i(clk), .reset_i(reset), .mode_req_i(mode_req),
        .valid_i(valid_i), .ready_o(a_ready), .data_i(data_i),
        .valid_o(a_valid), .ready_i(ready_i), .data_o(a_data),
        .mode_o(a_mode), .busy_o(a_busy), .frame_done_o(a_done),
        .frame_cnt_o(a_cnt)
    );

    frame_sequencer #(
        .width_p(4), .height_p(3), .data_width_p(1), .flush_rows_p(0)
    ) dut0 (
        .clk_i(clk), .reset_i(reset), .mode_req_i(mode_req),
        .valid_i(valid_i), .ready_o(b_ready), .data_i(data_i),
        .valid_o(b_valid), .ready_i(ready_i), .data_o(b_data),
        .mode_o(b_mode), .busy_o(b_busy), .frame_done_o(b_done),
        .frame_cnt_o(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_i = 1'b0;
        data_i  = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drives one frame into dut (flush_rows_p=2) and checks it cycle by cycle.
    task automatic run_frame(input bit bp, input logic [2:0] m0, input logic [2:0] m1,
                             input int abort_n, input logic [1:0] exp_mode,
                             output int pass_n, output int fl_n, output bit done);
        int cyc;
        bit exp_fd;
        bit fin;
        bit stop;
        bit hs;
        cyc = 0; exp_fd = 0; stop = 0; pass_n = 0; fl_n = 0; done = 0;
        mode_req = m0;
        valid_i  = 1'b1;
        data_i   = pat[0];
        while (!stop && cyc < 200) begin
            ready_i = bp ? cyc[0] : 1'b1;
            @(negedge clk);
            hs  = a_valid & ready_i;
            fin = 0;
            chk("frame_done", a_done, exp_fd);
            if (exp_fd) begin
                done = 1;
                chk("busy_at_done", a_busy, 0);
                stop = 1;
            end else if (cyc == 0) begin
                chk("idle_busy", a_busy, 0);
                chk("idle_ready", a_ready, 0);
                chk("idle_valid", a_valid, 0);
            end else if (pass_n < 12) begin
                chk("pass_busy", a_busy, 1);
                chk("pass_ready", a_ready, ready_i);
                chk("pass_data", a_data, data_i);
                chk("mode_hold", a_mode, exp_mode);
                if (hs) pass_n++;
            end else begin
                chk("flush_valid", a_valid, 1);
                chk("flush_ready", a_ready, 0);
                chk("flush_data", a_data, 0);
                chk("mode_hold", a_mode, exp_mode);
                if (hs) begin
                    fl_n++;
                    fin = (fl_n == 8);
                end
            end
            exp_fd = fin;
            @(posedge clk); #1;
            cyc++;
            if (pass_n >= 5) mode_req = m1;
            if (pass_n < 12) data_i = pat[pass_n];
            else begin
                valid_i = 1'b0;
                data_i  = 1'b0;
            end
            if (!stop && abort_n > 0 && fl_n == abort_n) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("abort_busy", a_busy, 0);
                chk("abort_done", a_done, 0);
                chk("abort_cnt", a_cnt, 0);
                chk("abort_valid", a_valid, 0);
                stop = 1;
            end
        end
        if (!stop) chk("frame_timeout", cyc, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int  p, f, idx;
        bit  d;
        bit  exp_busy, exp_done;
        reset = 1'b0; mode_req = 3'b000; valid_i = 1'b0; data_i = 1'b0; ready_i = 1'b1;
        @(posedge clk); #1;

        // Reset held two edges with valid_i high
        reset = 1'b1; valid_i = 1'b1; data_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", a_valid, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_data", a_data, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_mode", a_mode, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", a_ready, 0);
        chk("post_rst_busy", a_busy, 0);
        @(posedge clk); #1;
        do_reset();

        // Full frame, no backpressure, mode Gx
        run_frame(0, 3'b010, 3'b010, 0, 2'd2, p, f, d);
        chk("full_pass", p, 12);
        chk("full_flush", f, 8);
        chk("full_done", d, 1);
        chk("full_cnt", a_cnt, 1);
        chk("full_mode", a_mode, 2);

        // Backpressure every other cycle
        do_reset();
        run_frame(1, 3'b010, 3'b010, 0, 2'd2, p, f, d);
        chk("bp_pass", p, 12);
        chk("bp_flush", f, 8);
        chk("bp_done", d, 1);
        chk("bp_cnt", a_cnt, 1);

        // Mode gating
        run_frame(0, 3'b001, 3'b100, 0, 2'd1, p, f, d);
        chk("gate_mode", a_mode, 1);
        chk("gate_cnt", a_cnt, 2);
        run_frame(0, 3'b100, 3'b100, 0, 2'd3, p, f, d);
        chk("gate_next_mode", a_mode, 3);
        run_frame(0, 3'b011, 3'b011, 0, 2'd0, p, f, d);
        chk("invalid_mode", a_mode, 0);
        chk("gate_cnt4", a_cnt, 4);

        // Reset after three flush beats, then a clean frame
        do_reset();
        run_frame(0, 3'b010, 3'b010, 3, 2'd2, p, f, d);
        chk("abort_no_done", d, 0);
        run_frame(0, 3'b010, 3'b010, 0, 2'd2, p, f, d);
        chk("after_abort_pass", p, 12);
        chk("after_abort_flush", f, 8);
        chk("after_abort_cnt", a_cnt, 1);

        // flush_rows_p=0 instance: two back-to-back frames, valid held high
        do_reset();
        idx = 0;
        valid_i = 1'b1; ready_i = 1'b1; data_i = pat[0];
        for (int c = 0; c < 27; c++) begin
            exp_busy = !(c == 0 || c == 13 || c == 26);
            exp_done = (c == 13 || c == 26);
            @(negedge clk);
            chk("nf_busy", b_busy, exp_busy);
            chk("nf_done", b_done, exp_done);
            chk("nf_ready", b_ready, exp_busy);
            if (exp_busy) chk("nf_data", b_data, data_i);
            if (c == 13) chk("nf_cnt1", b_cnt, 1);
            @(posedge clk); #1;
            if (exp_busy) begin
                idx = (idx == 11) ? 0 : idx + 1;
                data_i = pat[idx];
            end
        end
        chk("nf_cnt2", b_cnt, 2);
        valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
